exec_shift_pipe: RTL

//  Pipelined, parametrised shift/rotate unit for the execute stage. Supersedes the single-cycle rotator.

---
 rtl/exec_shift_pipe_pkg.sv | 35 +++
 rtl/exec_shift_stage.sv | 121 ++++++++++++
 rtl/exec_shift_pipe.sv | 103 ++++++++++
 3 files changed

// File: rtl/exec_shift_pipe_pkg.sv
// rtl/exec_shift_pipe_pkg.sv - shared mode codes, flag indices and stage-split helpers
package exec_shift_pipe_pkg;

  localparam int W_OPR   = 32;
  localparam int W_AMT   = 5;
  localparam int STAGES  = 2;
  localparam int W_FLAGS = 4;

  typedef enum logic [2:0] {
    SHMODE_SHL = 3'd0,
    SHMODE_SHR = 3'd1,
    SHMODE_SAR = 3'd2,
    SHMODE_ROL = 3'd3,
    SHMODE_ROR = 3'd4
  } shmode_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_V = 3;

  // Leftover mux levels go to the earliest stages.
  function automatic int lvl_lo(input int stg, input int n_lvl, input int n_stg);
    int base;
    int rem;
    base = n_lvl / n_stg;
    rem  = n_lvl % n_stg;
    return stg * base + ((stg < rem) ? stg : rem);
  endfunction

  function automatic int lvl_hi(input int stg, input int n_lvl, input int n_stg);
    return lvl_lo(stg + 1, n_lvl, n_stg) - 1;
  endfunction

endpackage

// File: rtl/exec_shift_stage.sv
// rtl/exec_shift_stage.sv - one pipeline stage applying shift levels 2^LVL_LO..2^LVL_HI
module exec_shift_stage
  import exec_shift_pipe_pkg::*;
#(
  parameter int W_OPR  = 32,
  parameter int W_AMT  = 5,
  parameter int LVL_LO = 0,
  parameter int LVL_HI = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [W_OPR-1:0] i_data,
  input  logic [2:0]       i_mode,
  input  logic [W_AMT-1:0] i_amt,
  input  logic             i_msb,
  input  logic             i_cy,
  input  logic             i_ov,
  output logic             o_valid,
  output logic [W_OPR-1:0] o_data,
  output logic [2:0]       o_mode,
  output logic [W_AMT-1:0] o_amt,
  output logic             o_msb,
  output logic             o_cy,
  output logic             o_ov
);

  localparam int N_LVL = LVL_HI - LVL_LO + 1;

  logic [W_OPR-1:0] w_x  [0:N_LVL];
  logic             w_cy [0:N_LVL];
  logic             w_ov [0:N_LVL];

  assign w_x[0]  = i_data;
  assign w_cy[0] = i_cy;
  assign w_ov[0] = i_ov;

  // Each level selects from a double-width source: fill half is zero, sign or the operand itself.
  for (genvar j = 0; j < N_LVL; j++) begin : gen_lvl
    localparam int SH = 1 << (LVL_LO + j);
    logic [2*W_OPR-1:0] w_src;
    logic [W_OPR-1:0]   w_fill;
    logic [W_OPR-1:0]   w_xo;
    logic               w_cyo;
    logic               w_ovo;

    always_comb begin
      w_src  = '0;
      w_fill = '0;
      w_xo   = w_x[j];
      w_cyo  = w_cy[j];
      w_ovo  = w_ov[j];
      if (i_amt[LVL_LO+j]) begin
        case (i_mode)
          SHMODE_SHL, SHMODE_ROL: begin
            w_fill = (i_mode == SHMODE_ROL) ? w_x[j] : {W_OPR{1'b0}};
            w_src  = {w_x[j], w_fill};
            w_xo   = w_src[2*W_OPR-1-SH -: W_OPR];
            w_cyo  = w_x[j][W_OPR-SH];
            if ((i_mode == SHMODE_SHL) && (w_x[j][W_OPR-1 -: SH] != {SH{i_msb}})) begin
              w_ovo = 1'b1;
            end
          end
          SHMODE_SHR, SHMODE_SAR, SHMODE_ROR: begin
            if (i_mode == SHMODE_ROR) begin
              w_fill = w_x[j];
            end else if (i_mode == SHMODE_SAR) begin
              w_fill = {W_OPR{i_msb}};
            end
            w_src = {w_fill, w_x[j]};
            w_xo  = w_src[SH +: W_OPR];
            w_cyo = w_x[j][SH-1];
          end
          default: ;
        endcase
      end
    end

    assign w_x[j+1]  = w_xo;
    assign w_cy[j+1] = w_cyo;
    assign w_ov[j+1] = w_ovo;
  end

  logic             r_valid;
  logic [W_OPR-1:0] r_data;
  logic [2:0]       r_mode;
  logic [W_AMT-1:0] r_amt;
  logic             r_msb;
  logic             r_cy;
  logic             r_ov;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_valid <= i_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_data <= w_x[N_LVL];
      r_mode <= i_mode;
      r_amt  <= i_amt;
      r_msb  <= i_msb;
      r_cy   <= w_cy[N_LVL];
      r_ov   <= w_ov[N_LVL];
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_mode  = r_mode;
  assign o_amt   = r_amt;
  assign o_msb   = r_msb;
  assign o_cy    = r_cy;
  assign o_ov    = r_ov;

endmodule

// File: rtl/exec_shift_pipe.sv
// rtl/exec_shift_pipe.sv - pipelined shift/rotate unit with global stall, flush and flag generation
module exec_shift_pipe
  import exec_shift_pipe_pkg::*;
#(
  parameter int W_OPR   = exec_shift_pipe_pkg::W_OPR,
  parameter int W_AMT   = exec_shift_pipe_pkg::W_AMT,
  parameter int STAGES  = exec_shift_pipe_pkg::STAGES,
  parameter int W_FLAGS = exec_shift_pipe_pkg::W_FLAGS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [2:0]         mode_i,
  input  logic [W_OPR-1:0]   opr0_i,
  input  logic [W_OPR-1:0]   opr1_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [W_OPR-1:0]   result_o,
  output logic [W_FLAGS-1:0] flags_o
);

  logic             w_v   [0:STAGES];
  logic [W_OPR-1:0] w_d   [0:STAGES];
  logic [2:0]       w_m   [0:STAGES];
  logic [W_AMT-1:0] w_a   [0:STAGES];
  logic             w_msb [0:STAGES];
  logic             w_cy  [0:STAGES];
  logic             w_ov  [0:STAGES];
  logic             w_en;
  logic             w_unused_amt;

  assign w_en         = ~w_v[STAGES] | ready_i;
  assign ready_o      = w_en;
  assign w_unused_amt = ^opr1_i[W_OPR-1:W_AMT];

  assign w_v[0]   = valid_i;
  assign w_d[0]   = opr0_i;
  assign w_m[0]   = mode_i;
  assign w_a[0]   = opr1_i[W_AMT-1:0];
  assign w_msb[0] = opr0_i[W_OPR-1];
  assign w_cy[0]  = 1'b0;
  assign w_ov[0]  = 1'b0;

  for (genvar s = 0; s < STAGES; s++) begin : gen_stg
    exec_shift_stage #(
      .W_OPR  (W_OPR),
      .W_AMT  (W_AMT),
      .LVL_LO (lvl_lo(s, W_AMT, STAGES)),
      .LVL_HI (lvl_hi(s, W_AMT, STAGES))
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_en),
      .i_flush (flush_i),
      .i_valid (w_v[s]),
      .i_data  (w_d[s]),
      .i_mode  (w_m[s]),
      .i_amt   (w_a[s]),
      .i_msb   (w_msb[s]),
      .i_cy    (w_cy[s]),
      .i_ov    (w_ov[s]),
      .o_valid (w_v[s+1]),
      .o_data  (w_d[s+1]),
      .o_mode  (w_m[s+1]),
      .o_amt   (w_a[s+1]),
      .o_msb   (w_msb[s+1]),
      .o_cy    (w_cy[s+1]),
      .o_ov    (w_ov[s+1])
    );
  end

  logic [W_OPR-1:0]   w_res;
  logic               w_carry;
  logic [W_FLAGS-1:0] w_flags;

  // Rotates take carry from the finished result; shifts use the bit tracked through the levels.
  always_comb begin
    w_res   = w_d[STAGES];
    w_carry = 1'b0;
    case (w_m[STAGES])
      SHMODE_SHL, SHMODE_SHR, SHMODE_SAR: w_carry = w_cy[STAGES];
      SHMODE_ROL:                         w_carry = w_res[0];
      SHMODE_ROR:                         w_carry = w_res[W_OPR-1];
      default:                            w_carry = 1'b0;
    endcase
    if (w_a[STAGES] == '0) begin
      w_carry = 1'b0;
    end
    w_flags         = '0;
    w_flags[FLAG_C] = w_carry;
    w_flags[FLAG_Z] = ~|w_res;
    w_flags[FLAG_S] = w_res[W_OPR-1];
    w_flags[FLAG_V] = (w_m[STAGES] == SHMODE_SHL) &&
                      (w_ov[STAGES] || (w_res[W_OPR-1] != w_msb[STAGES]));
  end

  assign valid_o  = w_v[STAGES];
  assign result_o = valid_o ? w_res   : '0;
  assign flags_o  = valid_o ? w_flags : '0;

endmodule
